mask_regfile_mp: RTL

Multi-port, parametrised mask register file for the RVV vector unit: 2^ADDR_WIDTH mask registers of VLEN bits, accessed in DATA_WIDTH-bit beats with byte enables. It replaces the fixed two-read-port mask file. It adds a hardware init sweep, NUM_RD read ports, write-to-read bypass, and a one-entry retry buffer, so a load write that collides with an ALU write is deferred rather than dropped. It sits between the vector ALU writeback, the load/store unit and the mask-consuming lanes.

---
 rtl/mask_rf_pkg.sv | 25 ++
 rtl/mask_rf_ld_retry.sv | 62 ++++++
 rtl/mask_regfile_mp.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mask_rf_pkg.sv
// rtl/mask_rf_pkg.sv - shared types and derived constants for the mask register file
package mask_rf_pkg;

  localparam int VLEN_D       = 256;
  localparam int ADDR_WIDTH_D = 5;
  localparam int DATA_WIDTH_D = 64;
  localparam int DW_B_D       = DATA_WIDTH_D / 8;
  localparam int OFF_BITS_D   = $clog2(VLEN_D / DATA_WIDTH_D);
  localparam int NUM_REGS     = 2 ** ADDR_WIDTH_D;
  localparam int BEATS        = VLEN_D / DATA_WIDTH_D;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mrf_state_e;

  // Request layout is sized by the package constants; the top parameters default to them.
  typedef struct packed {
    logic [ADDR_WIDTH_D-1:0] addr;
    logic [OFF_BITS_D-1:0]   off;
    logic [DW_B_D-1:0]       be;
    logic [DATA_WIDTH_D-1:0] data;
  } mrf_wreq_t;

endpackage

// File: rtl/mask_rf_ld_retry.sv
// rtl/mask_rf_ld_retry.sv - one-entry retry buffer deferring loads that collide with the ALU write port
module mask_rf_ld_retry
  import mask_rf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_run,
  input  logic [DW_B_D-1:0]       i_wr_en,
  input  logic [ADDR_WIDTH_D-1:0] i_wr_addr,
  input  logic [OFF_BITS_D-1:0]   i_wr_off,
  input  mrf_wreq_t               i_ld,
  output logic                    o_cmt_valid,
  output mrf_wreq_t               o_cmt,
  output logic                    o_ld_ready,
  output logic [CNT_W-1:0]        o_conflict_cnt
);

  logic       r_pend_valid;
  mrf_wreq_t  r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic       w_wr_act;
  logic       w_pend_hit;
  logic       w_ld_hit;
  logic       w_ld_acc;

  assign w_wr_act   = |i_wr_en;
  assign w_pend_hit = w_wr_act && (r_pend.addr == i_wr_addr) && (r_pend.off == i_wr_off);
  assign w_ld_hit   = w_wr_act && (i_ld.addr == i_wr_addr) && (i_ld.off == i_wr_off);
  assign o_ld_ready = i_run & ~r_pend_valid;
  assign w_ld_acc   = o_ld_ready && (|i_ld.be);

  // The buffer blocks new loads, so at most one of pend/ld commits per cycle.
  always_comb begin
    o_cmt_valid = 1'b0;
    o_cmt       = r_pend;
    if (r_pend_valid) begin
      o_cmt_valid = ~w_pend_hit;
    end else if (w_ld_acc && !w_ld_hit) begin
      o_cmt_valid = 1'b1;
      o_cmt       = i_ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
      r_cnt        <= '0;
    end else if (r_pend_valid) begin
      if (!w_pend_hit) r_pend_valid <= 1'b0;
    end else if (w_ld_acc && w_ld_hit) begin
      r_pend_valid <= 1'b1;
      r_pend       <= i_ld;
      if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_conflict_cnt = r_cnt;

endmodule

// File: rtl/mask_regfile_mp.sv
// rtl/mask_regfile_mp.sv - multi-port RVV mask register file with init sweep, bypass and load retry
module mask_regfile_mp
  import mask_rf_pkg::*;
#(
  parameter int VLEN       = VLEN_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int DW_B       = DATA_WIDTH / 8,
  parameter int OFF_BITS   = $clog2(VLEN / DATA_WIDTH),
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD*DW_B-1:0]         rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  input  logic [NUM_RD*OFF_BITS-1:0]     rd_off,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_out,
  output logic [NUM_RD-1:0]              rd_valid,
  input  logic [DW_B-1:0]                wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [OFF_BITS-1:0]            wr_off,
  input  logic [DATA_WIDTH-1:0]          wr_data_in,
  input  logic [DW_B-1:0]                ld_en,
  input  logic [ADDR_WIDTH-1:0]          ld_addr,
  input  logic [OFF_BITS-1:0]            ld_off,
  input  logic [DATA_WIDTH-1:0]          ld_data_in,
  output logic                           ld_ready,
  input  logic [DW_B-1:0]                st_en,
  input  logic [ADDR_WIDTH-1:0]          st_addr,
  input  logic [OFF_BITS-1:0]            st_off,
  output logic [DATA_WIDTH-1:0]          st_data_out,
  output logic                           st_valid,
  output logic                           init_done,
  output logic [CNT_W-1:0]               conflict_cnt
);

  localparam int ENTRIES = (2 ** ADDR_WIDTH) * (VLEN / DATA_WIDTH);
  localparam int IDX_W   = ADDR_WIDTH + OFF_BITS;

  mrf_state_e                  r_state;
  mrf_state_e                  w_state_nxt;
  logic [IDX_W-1:0]            r_sweep;
  logic                        r_init_done;
  logic                        w_run;
  logic [DATA_WIDTH-1:0]       r_mem [ENTRIES];
  logic [IDX_W-1:0]            w_wr_idx;
  logic [IDX_W-1:0]            w_cmt_idx;
  logic [IDX_W-1:0]            w_st_idx;
  mrf_wreq_t                   w_ld_req;
  mrf_wreq_t                   w_cmt;
  logic                        w_cmt_valid;
  logic [NUM_RD*DATA_WIDTH-1:0] r_rd_data;
  logic [NUM_RD-1:0]           r_rd_valid;
  logic [DATA_WIDTH-1:0]       r_st_data;
  logic                        r_st_valid;

  assign w_run     = (r_state == RUN);
  assign w_wr_idx  = {wr_addr, wr_off};
  assign w_st_idx  = {st_addr, st_off};
  assign w_cmt_idx = {w_cmt.addr, w_cmt.off};
  assign w_ld_req  = '{addr: ld_addr, off: ld_off, be: ld_en, data: ld_data_in};

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT && r_sweep == IDX_W'(ENTRIES - 1)) w_state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT;
      r_sweep     <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == RUN);
      if (r_state == INIT) r_sweep <= r_sweep + IDX_W'(1);
    end
  end

  mask_rf_ld_retry #(
    .CNT_W (CNT_W)
  ) u_ld_retry (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_run          (r_init_done),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_wr_off       (wr_off),
    .i_ld           (w_ld_req),
    .o_cmt_valid    (w_cmt_valid),
    .o_cmt          (w_cmt),
    .o_ld_ready     (ld_ready),
    .o_conflict_cnt (conflict_cnt)
  );

  // The wr port is applied last so it wins any overlap with a committed load.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_sweep] <= '1;
    end else begin
      for (int b = 0; b < DW_B; b++) begin
        if (w_cmt_valid && w_cmt.be[b]) r_mem[w_cmt_idx][b*8 +: 8] <= w_cmt.data[b*8 +: 8];
      end
      for (int b = 0; b < DW_B; b++) begin
        if (wr_en[b]) r_mem[w_wr_idx][b*8 +: 8] <= wr_data_in[b*8 +: 8];
      end
    end
  end

  function automatic logic [7:0] f_rd_byte(input logic [IDX_W-1:0] idx, input int b);
    if (BYPASS != 0 && wr_en[b] && idx == w_wr_idx) return wr_data_in[b*8 +: 8];
    return r_mem[idx][b*8 +: 8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_st_data  <= '0;
      r_st_valid <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        r_rd_valid[p] <= w_run && (|rd_en[p*DW_B +: DW_B]);
        for (int b = 0; b < DW_B; b++) begin
          if (w_run && rd_en[p*DW_B + b])
            r_rd_data[p*DATA_WIDTH + b*8 +: 8] <=
              f_rd_byte({rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH], rd_off[p*OFF_BITS +: OFF_BITS]}, b);
        end
      end
      r_st_valid <= w_run && (|st_en);
      for (int b = 0; b < DW_B; b++) begin
        if (w_run && st_en[b]) r_st_data[b*8 +: 8] <= f_rd_byte(w_st_idx, b);
      end
    end
  end

  assign rd_data_out = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign st_data_out = r_st_data;
  assign st_valid    = r_st_valid;
  assign init_done   = r_init_done;

endmodule
